// File: rtl/lseq_pkg.sv
// Shared definitions for the serial-load sequencer: state encodings,
// default frame sizes and the bit-counter width helper.
package lseq_pkg;

  localparam int KEY_SIZE_DEF = 8;
  localparam int MSG_SIZE_DEF = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CLEAR       = 3'd1,
    LOAD_KEY    = 3'd2,
    LOAD_MSG    = 3'd3,
    CIPHER      = 3'd4,
    WAIT_CIPHER = 3'd5,
    OUTPUT      = 3'd6,
    DONE        = 3'd7
  } state_t;

  // One spare bit keeps the terminal value representable for any size.
  function automatic int cnt_width(input int key_size, input int msg_size);
    return $clog2((key_size > msg_size) ? key_size : msg_size) + 1;
  endfunction

endpackage

// File: rtl/lseq_bit_counter.sv
// Strobe-gated bit counter; last_bit flags the strobe that hits the limit,
// and the counter wraps to zero on that same strobe.
module lseq_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             last_bit
);

  logic [WIDTH-1:0] count;

  assign last_bit = enable && (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || last_bit) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/load_sequencer.sv
// Frame controller for the serial-load crypto datapath: clear, key load,
// message load, cipher start, output. Optional key reuse: LSEQ_KEY_REUSE_EN.
module load_sequencer
  import lseq_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int MSG_SIZE = MSG_SIZE_DEF
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEn,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iKey_reuse,
  input  logic       iCipher_done,
  input  logic       iOut_done,
  output logic       oKey_clr_n,
  output logic       oMsg_clr_n,
  output logic       oKey_load,
  output logic       oMsg_load,
  output logic       oCipher_start,
  output logic       oOut_en,
  output logic       oBusy,
  output logic       oDone,
  output logic [2:0] oState
);

  localparam int CNT_W = cnt_width(KEY_SIZE, MSG_SIZE);

  state_t           state;
  state_t           next_state;
  logic             in_load;
  logic             last_bit;
  logic [CNT_W-1:0] limit;
  logic             reuse_key;
  logic             cipher_start;
  logic             done_pulse;

  assign in_load = (state == LOAD_KEY) || (state == LOAD_MSG);
  assign limit   = (state == LOAD_MSG) ? CNT_W'(MSG_SIZE - 1) : CNT_W'(KEY_SIZE - 1);

  lseq_bit_counter #(
    .WIDTH(CNT_W)
  ) bit_counter (
    .clk     (iClk),
    .rst_n   (iRst),
    .clear   (!in_load || iAbort),
    .enable  (in_load && iEn),
    .limit   (limit),
    .last_bit(last_bit)
  );

`ifdef LSEQ_KEY_REUSE_EN
  // Reuse choice is latched with the start request and steers CLEAR.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      reuse_key <= 1'b0;
    end else if (state == IDLE && iStart) begin
      reuse_key <= iKey_reuse;
    end
  end
`else
  logic unused_key_reuse;
  assign unused_key_reuse = iKey_reuse;
  assign reuse_key        = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state        <= IDLE;
      cipher_start <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      state        <= next_state;
      cipher_start <= (next_state == CIPHER);
      done_pulse   <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (iStart) next_state = CLEAR;
      CLEAR:       next_state = reuse_key ? LOAD_MSG : LOAD_KEY;
      LOAD_KEY:    if (last_bit) next_state = LOAD_MSG;
      LOAD_MSG:    if (last_bit) next_state = CIPHER;
      CIPHER:      next_state = WAIT_CIPHER;
      WAIT_CIPHER: if (iCipher_done) next_state = OUTPUT;
      OUTPUT:      if (iOut_done) next_state = DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
    // Abort overrides everything except an idle start request.
    if (iAbort && state != IDLE) next_state = IDLE;
  end

  assign oKey_clr_n    = !(state == CLEAR && !reuse_key);
  assign oMsg_clr_n    = !(state == CLEAR);
  assign oKey_load     = (state == LOAD_KEY);
  assign oMsg_load     = (state == LOAD_MSG);
  assign oCipher_start = cipher_start;
  assign oOut_en       = (state == OUTPUT);
  assign oBusy         = (state != IDLE);
  assign oDone         = done_pulse;
  assign oState        = state;

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Top-level controller for the serial-load crypto datapath.
- Sequences one frame through the following steps:
  - clears the key and message deserializers;
  - steers the shared serial bit stream first into the key deserializer (KEY_SIZE bits), then into the message deserializer (MSG_SIZE bits);
  - starts the cipher;
  - enables the output stage until it reports completion.
- Sits between the pin-level serial interface and the deserializer/cipher/output blocks.
- Owns their load flags and clear strobes.

Parameters:
- KEY_SIZE, 8, key length in bits (>=2).
- MSG_SIZE, 8, message length in bits (>=2).
- CNT_W, $clog2(max(KEY_SIZE,MSG_SIZE))+1, internal bit-counter width (derived, not overridden).

Ports:
- iClk  in  1  system clock, rising edge.
- iRst  in  1  asynchronous active-low reset.
- iEn  in  1  serial bit strobe; one data bit is valid on the serial line in each cycle iEn=1.
- iStart  in  1  single-cycle request to begin a frame.
- iAbort  in  1  abandon current frame.
- iKey_reuse  in  1  skip key load (honoured only with LSEQ_KEY_REUSE_EN).
- iCipher_done  in  1  cipher finished pulse.
- iOut_done  in  1  output stage finished pulse.
- oKey_clr_n  out  1  active-low clear to key deserializer.
- oMsg_clr_n  out  1  active-low clear to message deserializer.
- oKey_load  out  1  load flag to key deserializer.
- oMsg_load  out  1  load flag to message deserializer.
- oCipher_start  out  1  one-cycle cipher start.
- oOut_en  out  1  output stage enable.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle frame-complete pulse.
- oState  out  3  current state encoding, for debug.

Behaviour:
- Reset (iRst=0, async):
  - state=IDLE, counter=0.
  - oKey_clr_n=oMsg_clr_n=1.
  - All other outputs 0.
- Outputs are Moore decodes of registered state, except oCipher_start and oDone, which are registered pulses.
- States and encodings: IDLE=0, CLEAR=1, LOAD_KEY=2, LOAD_MSG=3, CIPHER=4, WAIT_CIPHER=5, OUTPUT=6, DONE=7.
- IDLE:
  - iStart=1 -> CLEAR.
  - iEn bits arriving in IDLE are discarded.
- CLEAR (1 cycle):
  - oKey_clr_n=0 and oMsg_clr_n=0.
  - counter<=0.
  - Next state: LOAD_KEY.
- LOAD_KEY:
  - oKey_load=1.
  - On each cycle with iEn=1, counter++.
  - When counter==KEY_SIZE-1 and iEn=1: counter<=0, next state LOAD_MSG.
  - The key deserializer therefore receives exactly KEY_SIZE strobes. There is no bubble: the next iEn bit, even in the immediately following cycle, goes to the message deserializer.
- LOAD_MSG:
  - oMsg_load=1.
  - Same counting rule with MSG_SIZE.
  - On the last bit: next state CIPHER.
- CIPHER (1 cycle): oCipher_start=1, then WAIT_CIPHER.
- WAIT_CIPHER: hold until iCipher_done=1, then OUTPUT.
- OUTPUT: oOut_en=1 until iOut_done=1, then DONE.
- DONE (1 cycle): oDone=1, then IDLE.
- iStart while oBusy=1: ignored.
- iAbort=1 in any non-IDLE state:
  - Next state IDLE; counter<=0.
  - Load and enable outputs drop the next cycle.
  - iAbort has priority over every other transition in the same cycle.
  - If iAbort=1 and iStart=1 in IDLE: iStart wins (abort is a no-op there).
- iEn=0 during a load state: counter holds; no timeout.
- iCipher_done/iOut_done outside their wait states: ignored.
- Latency, with iEn=1 every cycle and immediate done responses: iStart to oDone = 1 + KEY_SIZE + MSG_SIZE + 1 + 1 + 1 + 1 cycles.

Optional Feature:
- LSEQ_KEY_REUSE_EN defined:
  - iKey_reuse is sampled on the iStart cycle.
  - If iKey_reuse=1: CLEAR drives only oMsg_clr_n=0 (oKey_clr_n stays 1), and the next state is LOAD_MSG, skipping LOAD_KEY.
  - A reuse frame is shorter than a full frame by KEY_SIZE cycles.
- LSEQ_KEY_REUSE_EN undefined: iKey_reuse is ignored; every frame reloads the key.

Decomposition:
- Shared package lseq_pkg:
  - state enum (3-bit encodings above);
  - KEY_SIZE/MSG_SIZE defaults;
  - CNT_W derivation function.
- One natural sub-module: lseq_bit_counter, the enable-gated counter with a terminal-count compare. Inputs: clear, enable, limit. Output: last_bit flag.
- The FSM stays in load_sequencer.

Test Plan:
1. Basic frame:
   - Stimulus: iStart, then 16 consecutive iEn with key 0xA5 and message 0x3C; iCipher_done 2 cycles after oCipher_start; iOut_done 3 cycles after oOut_en.
   - Required: oKey_load high for exactly 8 iEn cycles; oMsg_load high for exactly 8; the deserializers hold 0xA5/0x3C; oDone is a single pulse.
2. Sparse strobes:
   - Stimulus: iEn asserted every 3rd cycle.
   - Required: the counter advances only on strobes; the LOAD_KEY->LOAD_MSG handoff occurs on exactly the 8th strobe; no bit is lost or duplicated.
3. Abort:
   - Stimulus: iAbort after 5 key bits.
   - Required: the next cycle has state=IDLE, oKey_load=0, oBusy=0.
   - Follow-up: a new iStart produces a CLEAR with both clears low, and a full frame completes correctly.
4. Start while busy:
   - Stimulus: iStart pulses in LOAD_MSG and in OUTPUT.
   - Required: no state change; oDone fires once.
5. Reset mid-operation:
   - Stimulus: drive iRst low asynchronously during WAIT_CIPHER.
   - Required: all outputs return to reset values immediately; oState=0.
6. Key reuse (LSEQ_KEY_REUSE_EN defined):
   - Stimulus: iKey_reuse=1 with iStart.
   - Required: oKey_clr_n stays 1; LOAD_KEY is skipped; iStart to oDone = 13 cycles with immediate done responses.
   - Undefined-macro build: the same stimulus takes 21 cycles.
